// File: rtl/lomo_frame_rx.sv
// rtl/lomo_frame_rx.sv - LOMO serial telemetry receiver: bit/word recovery, header alignment, lock tracking
//
// Ports:
//   clk, reset          system clock, synchronous active-low reset
//   ser_clk, ser_dat    serial bit clock / data (async); bit taken on ser_clk falling edge
//   ser_mk              optional word-0 marker, rising edge restarts word 0
//   word_data/word_idx  last received word (bit0 = first on line) and its index
//   word_valid          one-cycle strobe for word_data/word_idx, only while locked
//   frm_num/str_num     frame/string numbers from the last good header
//   hdr_valid/hdr_err   one-cycle strobes for a good / bad header
//   locked              high while aligned
//   err_cnt             bad headers seen while locked, saturating
module lomo_frame_rx #(
  parameter int GAP_CYCLES = 64,
  parameter int LOCK_HDRS  = 2,
  parameter int LOSS_HDRS  = 3,
  parameter int WORDS      = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ser_clk,
  input  logic        ser_dat,
  input  logic        ser_mk,
  output logic [15:0] word_data,
  output logic [4:0]  word_idx,
  output logic        word_valid,
  output logic [8:0]  frm_num,
  output logic [5:0]  str_num,
  output logic        hdr_valid,
  output logic        hdr_err,
  output logic        locked,
  output logic [7:0]  err_cnt
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;
  state_t state_q, state_d;

  logic [2:0]    clk_sync, mk_sync;
  // Data is used at stage 2 together with the clock edge detect, so a third
  // data stage would drive nothing.
  logic [1:0]    dat_sync;
  logic [GW-1:0] gap_cnt;
  logic [3:0]    bit_cnt, good_cnt, bad_cnt, good_d, bad_d;
  logic [4:0]    word_cnt;
  logic [15:0]   shift;
  logic          slip, prev_good;

  logic          strobe, bit_in, mk_edge, resync;
  logic [3:0]    bit_cnt_eff;
  logic [4:0]    word_cnt_eff;
  logic          slip_eff, word_done, is_hdr, hdr_ok;
  logic [15:0]   new_word;
  logic [5:0]    str_inc;
  logic [8:0]    frm_next;

  assign strobe  = !clk_sync[1] && clk_sync[2];
  assign bit_in  = dat_sync[1];
  assign mk_edge = mk_sync[1] && !mk_sync[2];

  // A marker or a long silence restarts word 0 before this cycle's bit is
  // applied, so a bit arriving with the marker becomes bit0 of word 0.
  assign resync       = mk_edge || (gap_cnt == GAP_MAX);
  assign bit_cnt_eff  = resync ? 4'd0 : bit_cnt;
  assign word_cnt_eff = resync ? 5'd0 : word_cnt;
  assign slip_eff     = resync ? 1'b0 : slip;

  assign new_word  = {bit_in, shift[15:1]};
  assign word_done = strobe && !slip_eff && (bit_cnt_eff == 4'd15);
  assign is_hdr    = word_done && ((word_cnt_eff == 5'd0) || (word_cnt_eff == 5'(WORDS / 2)));

  // frm_num/str_num double as the continuity reference: they only load on a
  // good header, and prev_good says whether the last header was good.
  assign str_inc  = str_num + 6'd1;
  assign frm_next = (str_num == 6'd63) ? frm_num + 9'd1 : frm_num;

  always_comb begin
    hdr_ok = 1'b0;
    if (word_cnt_eff == 5'd0)
      hdr_ok = new_word[0] && !new_word[1] &&
               (!prev_good || (new_word[6:1] == str_inc && new_word[15:7] == frm_next));
    else
      hdr_ok = !new_word[0] &&
               (!prev_good || (new_word[6:1] == str_inc && new_word[15:7] == frm_num));
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_cnt;
    bad_d   = bad_cnt;
    if (is_hdr) begin
      case (state_q)
        HUNT: begin
          if (!hdr_ok) begin
            good_d = 4'd0;
          end else if (good_cnt + 4'd1 == 4'(LOCK_HDRS)) begin
            state_d = LOCKED;
            good_d  = 4'd0;
            bad_d   = 4'd0;
          end else begin
            good_d = good_cnt + 4'd1;
          end
        end
        LOCKED: begin
          if (hdr_ok) begin
            bad_d = 4'd0;
          end else if (bad_cnt + 4'd1 == 4'(LOSS_HDRS)) begin
            state_d = HUNT;
            good_d  = 4'd0;
            bad_d   = 4'd0;
          end else begin
            bad_d = bad_cnt + 4'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= HUNT;
      good_cnt <= 4'd0;
      bad_cnt  <= 4'd0;
    end else begin
      state_q  <= state_d;
      good_cnt <= good_d;
      bad_cnt  <= bad_d;
    end
  end

  assign locked = (state_q == LOCKED);

  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_sync   <= 3'd0;
      dat_sync   <= 2'd0;
      mk_sync    <= 3'd0;
      gap_cnt    <= '0;
      bit_cnt    <= 4'd0;
      word_cnt   <= 5'd0;
      shift      <= 16'd0;
      slip       <= 1'b0;
      prev_good  <= 1'b0;
      word_data  <= 16'd0;
      word_idx   <= 5'd0;
      word_valid <= 1'b0;
      frm_num    <= 9'd0;
      str_num    <= 6'd0;
      hdr_valid  <= 1'b0;
      hdr_err    <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      clk_sync   <= {clk_sync[1:0], ser_clk};
      dat_sync   <= {dat_sync[0], ser_dat};
      mk_sync    <= {mk_sync[1:0], ser_mk};
      word_valid <= 1'b0;
      hdr_valid  <= 1'b0;
      hdr_err    <= 1'b0;
      bit_cnt    <= bit_cnt_eff;
      word_cnt   <= word_cnt_eff;
      slip       <= slip_eff;

      if (strobe)
        gap_cnt <= '0;
      else if (gap_cnt != GAP_MAX)
        gap_cnt <= gap_cnt + GW'(1);

      if (strobe) begin
        if (slip_eff) begin
          // Bit slip: drop this bit so the next word starts one bit later.
          slip <= 1'b0;
        end else begin
          shift   <= new_word;
          bit_cnt <= bit_cnt_eff + 4'd1;
          if (word_done) begin
            word_data  <= new_word;
            word_idx   <= word_cnt_eff;
            word_valid <= (state_q == LOCKED);
            word_cnt   <= (word_cnt_eff == 5'(WORDS - 1)) ? 5'd0 : word_cnt_eff + 5'd1;
            if (is_hdr) begin
              if (hdr_ok) begin
                hdr_valid <= 1'b1;
                frm_num   <= new_word[15:7];
                str_num   <= new_word[6:1];
                prev_good <= 1'b1;
              end else begin
                hdr_err   <= 1'b1;
                prev_good <= 1'b0;
                if (state_q == LOCKED) begin
                  if (err_cnt != 8'hFF)
                    err_cnt <= err_cnt + 8'd1;
                end else begin
                  slip     <= 1'b1;
                  word_cnt <= 5'd0;
                end
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lomo_frame_rx.sv
// tb/tb_lomo_frame_rx.sv - randomized self-checking bench for lomo_frame_rx against a word-level reference model
module tb_lomo_frame_rx;

  logic        clk, reset, ser_clk, ser_dat, ser_mk;
  logic [15:0] word_data;
  logic [4:0]  word_idx;
  logic        word_valid, hdr_valid, hdr_err, locked;
  logic [8:0]  frm_num;
  logic [5:0]  str_num;
  logic [7:0]  err_cnt;

  lomo_frame_rx dut (
    .clk(clk), .reset(reset), .ser_clk(ser_clk), .ser_dat(ser_dat), .ser_mk(ser_mk),
    .word_data(word_data), .word_idx(word_idx), .word_valid(word_valid),
    .frm_num(frm_num), .str_num(str_num), .hdr_valid(hdr_valid), .hdr_err(hdr_err),
    .locked(locked), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stream tokens: 0/1 = data bit, 2 = 100-clk silence, 3 = marker on next bit, 4 = reset pulse
  int          tok[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          checks, errors;
  int          half;
  bit          mk_next, prev_locked;

  // Reference model state
  int m_cur[$];
  bit m_locked, m_slip, m_pg;
  int m_good, m_bad, m_err, m_wordc, m_frm, m_str;
  int g_frm, g_str;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (word_valid) got_q.push_back({4'h1, 7'd0, word_idx, word_data});
    if (hdr_valid)  got_q.push_back({4'h2, 13'd0, frm_num, str_num});
    if (hdr_err)    got_q.push_back({4'h3, 20'd0, err_cnt});
    if (locked != prev_locked) got_q.push_back({4'h4, 27'd0, locked});
    prev_locked = locked;
  end

  task automatic model_reset();
    m_cur.delete();
    m_locked = 0; m_slip = 0; m_pg = 0;
    m_good = 0; m_bad = 0; m_err = 0; m_wordc = 0; m_frm = 0; m_str = 0;
  endtask

  task automatic model_word();
    int w, idx, frm, str, flag;
    bit ok;
    w = 0;
    for (int i = 0; i < 16; i++) w += m_cur[i] << i;
    m_cur.delete();
    idx = m_wordc;
    if (m_locked) exp_q.push_back({4'h1, 7'd0, 5'(idx), 16'(w)});
    m_wordc = (m_wordc + 1) % 20;
    if (idx != 0 && idx != 10) return;
    frm  = w / 128;
    str  = (w / 2) % 64;
    flag = w % 2;
    if (idx == 0)
      ok = flag == 1 && str % 2 == 0 &&
           (!m_pg || (str == (m_str + 1) % 64 &&
                      frm == ((m_str == 63) ? (m_frm + 1) % 512 : m_frm)));
    else
      ok = flag == 0 && (!m_pg || (str == (m_str + 1) % 64 && frm == m_frm));
    if (ok) begin
      m_pg = 1; m_frm = frm; m_str = str;
      exp_q.push_back({4'h2, 13'd0, 9'(frm), 6'(str)});
      if (m_locked) m_bad = 0;
      else begin
        m_good++;
        if (m_good == 2) begin
          m_locked = 1; m_good = 0; m_bad = 0;
          exp_q.push_back({4'h4, 28'd1});
        end
      end
    end else begin
      m_pg = 0;
      if (m_locked) begin
        if (m_err < 255) m_err++;
        exp_q.push_back({4'h3, 20'd0, 8'(m_err)});
        m_bad++;
        if (m_bad == 3) begin
          m_locked = 0; m_good = 0; m_bad = 0;
          exp_q.push_back({4'h4, 28'd0});
        end
      end else begin
        exp_q.push_back({4'h3, 20'd0, 8'(m_err)});
        m_good = 0; m_slip = 1; m_wordc = 0;
      end
    end
  endtask

  task automatic emit(input int t);
    tok.push_back(t);
    case (t)
      0, 1: begin
        if (m_slip) m_slip = 0;
        else begin
          m_cur.push_back(t);
          if (m_cur.size() == 16) model_word();
        end
      end
      2, 3: begin m_cur.delete(); m_wordc = 0; m_slip = 0; end
      default: begin
        if (m_locked) exp_q.push_back({4'h4, 28'd0});
        model_reset();
      end
    endcase
  endtask

  // One 20-word string pair from the imitator; bits outside [skip, nbits) are not sent.
  task automatic gen_pair(input int frm, input int str, input bit f0, input bit f10,
                          input int skip, input int nbits);
    int w;
    for (int i = 0; i < 20; i++) begin
      if (i == 0)       w = frm * 128 + str * 2 + 1;
      else if (i == 10) w = frm * 128 + (str + 1) * 2;
      else              w = 'h44D0 + (i + 5) % 16;
      if ((i == 0 && f0) || (i == 10 && f10)) w = w ^ 1;
      for (int b = 0; b < 16; b++)
        if (i * 16 + b >= skip && i * 16 + b < nbits) emit((w >> b) & 1);
    end
  endtask

  task automatic next_pair();
    if (g_str == 62) begin g_str = 0; g_frm = (g_frm + 1) % 512; end
    else g_str += 2;
  endtask

  task automatic add_pair(input bit f0, input bit f10);
    gen_pair(g_frm, g_str, f0, f10, 0, 320);
    next_pair();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_all();
    foreach (tok[k]) begin
      case (tok[k])
        0, 1: begin
          ser_clk = 1'b1; ser_dat = tok[k][0]; ser_mk = 1'b0;
          tick(half);
          ser_clk = 1'b0; ser_mk = mk_next; mk_next = 1'b0;
          tick(half);
        end
        2: tick(100);
        3: mk_next = 1'b1;
        default: begin
          tick(4);
          reset = 1'b0;
          tick(1);
          check("rst_word", {10'd0, word_valid, word_idx, word_data}, 32'd0);
          check("rst_hdr", {7'd0, hdr_valid, hdr_err, locked, err_cnt, frm_num, str_num}, 32'd0);
          reset = 1'b1;
        end
      endcase
    end
    tok.delete();
  endtask

  task automatic compare(input string tag);
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    check({tag, "_nev"}, got_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) check($sformatf("%s_ev%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_state(input string tag);
    check({tag, "_locked"}, locked, m_locked);
    check({tag, "_err"}, err_cnt, m_err);
    check({tag, "_frm"}, frm_num, m_frm);
    check({tag, "_str"}, str_num, m_str);
  endtask

  initial begin
    checks = 0; errors = 0; mk_next = 0; prev_locked = 0;
    reset = 1'b0; ser_clk = 1'b0; ser_dat = 1'b0; ser_mk = 1'b0;
    model_reset();
    tick(3);

    // Aligned stream from frame 511 near the end of the string range: lock and frame wrap
    emit(4);
    g_frm = 511;
    g_str = 2 * $urandom_range(29, 31);
    for (int p = 0; p < 4; p++) add_pair(0, 0);
    emit(2);
    half = $urandom_range(2, 3);
    drive_all();
    compare("wrap");
    check_state("wrap");
    check("wrap_frm0", frm_num, 32'd0);
    check("wrap_noerr", err_cnt, 32'd0);

    // Stream joined 5 bits late without a marker: hunt by bit slips until lock
    emit(4);
    g_frm = $urandom_range(0, 511);
    g_str = 2 * $urandom_range(0, 31);
    gen_pair(g_frm, g_str, 0, 0, 5, 320);
    next_pair();
    for (int p = 0; p < 40 && !m_locked; p++) add_pair(0, 0);
    add_pair(0, 0);
    emit(2);
    half = 2;
    drive_all();
    compare("hunt");
    check_state("hunt");

    // Three consecutive corrupted header flags while locked, then clean relock
    for (int p = $urandom_range(0, 1); p > 0; p--) add_pair(0, 0);
    add_pair(1, 1);
    add_pair(1, 0);
    add_pair(0, 0);
    add_pair(0, 0);
    emit(2);
    half = $urandom_range(2, 3);
    drive_all();
    compare("flip");
    check_state("flip");

    // Clock stops mid-word, restart on a word-0 boundary with marker
    gen_pair(g_frm, g_str, 0, 0, 0, 15 * 16 + 7);
    next_pair();
    emit(2);
    emit(3);
    add_pair(0, 0);
    add_pair(0, 0);
    emit(2);
    half = $urandom_range(2, 3);
    drive_all();
    compare("gap");
    check_state("gap");

    // Reset mid-word while locked, then relock on following headers
    gen_pair(g_frm, g_str, 0, 0, 0, 6 * 16 + 9);
    next_pair();
    emit(4);
    for (int p = 0; p < 3; p++) add_pair(0, 0);
    emit(2);
    half = $urandom_range(2, 3);
    drive_all();
    compare("rst");
    check_state("rst");
    check("rst_relock", locked, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
